// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between CPU and DMA; define MEM_ARB_RR_EN for round-robin ties, else the CPU wins ties.
// Latency: ack is LAT+1 cycles after a request is sampled in IDLE; one transaction per LAT+2 cycles.
// Backpressure: requesters hold req and operands until their one-cycle ack; requests outside IDLE simply wait.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          last_owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          any_req;
    logic          pick_dma;

    assign any_req = cpu_req | dma_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not complete last goes next.
    assign pick_dma = dma_req & (~cpu_req | ~last_owner);
`else
    assign pick_dma = dma_req & ~cpu_req;

    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= pick_dma;
                        lat_we    <= pick_dma ? dma_we    : cpu_we;
                        lat_addr  <= pick_dma ? dma_addr  : cpu_addr;
                        lat_wdata <= pick_dma ? dma_wdata : cpu_wdata;
                        cnt       <= CNT_INIT;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Memory read data is only valid in the final access cycle.
                        if (!lat_we) begin
                            if (owner) begin
                                dma_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                        last_owner <= owner;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign cpu_ack   = (state == DONE) & ~owner;
    assign dma_ack   = (state == DONE) & owner;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized CPU/DMA traffic against a cycle-count transaction model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          cpu_ack, dma_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, owner;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_seed(input int i);
        if (i == 'h40) return 32'hDEADBEEF;
        if (i == 'h80) return 32'hCAFEF00D;
        return 32'h5A5A0000 | 32'(i * 7);
    endfunction

    // Bench memory: combinational read, write on the clock; reloaded whenever reset is low.
    logic [DW-1:0] tb_mem [0:255];
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= mem_seed(i);
        end else if (mem_en && mem_we) begin
            tb_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // Transaction model: a grant at edge e0 owns the memory for edges e0..e0+LAT+1.
    logic [DW-1:0] ref_mem [0:255];
    int            cyc = 0;
    int            m_e0 = 0;
    bit            m_valid = 1'b0;
    bit            m_own = 1'b0;
    bit            m_last = 1'b1;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] e_cpu_rd = '0;
    logic [DW-1:0] e_dma_rd = '0;

    always @(posedge clk) begin
        bit idle;
        bit win;
        cyc++;
        if (!reset) begin
            m_valid  = 1'b0;
            m_own    = 1'b0;
            m_last   = 1'b1;
            e_cpu_rd = '0;
            e_dma_rd = '0;
            for (int i = 0; i < 256; i++) ref_mem[i] = mem_seed(i);
        end else begin
            idle = !m_valid;
            if (m_valid && cyc == m_e0 + LAT) begin
                if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                else if (m_own) e_dma_rd = ref_mem[m_addr[7:0]];
                else e_cpu_rd = ref_mem[m_addr[7:0]];
                m_last = m_own;
            end
            if (m_valid && cyc == m_e0 + LAT + 1) m_valid = 1'b0;
            if (idle && (cpu_req || dma_req)) begin
`ifdef MEM_ARB_RR_EN
                win = (cpu_req && dma_req) ? !m_last : dma_req;
`else
                win = !cpu_req;
`endif
                m_valid = 1'b1;
                m_e0    = cyc;
                m_own   = win;
                m_we    = win ? dma_we : cpu_we;
                m_addr  = win ? dma_addr : cpu_addr;
                m_wdata = win ? dma_wdata : cpu_wdata;
            end
        end
    end

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        int d;
        bit e_en;
        bit e_ack;
        if (chk_on) begin
            d     = cyc - m_e0;
            e_en  = m_valid && d < LAT;
            e_ack = m_valid && d == LAT;
            check("mem_en", 64'(mem_en), 64'(e_en));
            check("mem_we", 64'(mem_we), 64'(e_en && m_we));
            check("busy", 64'(busy), 64'(m_valid));
            check("cpu_ack", 64'(cpu_ack), 64'(e_ack && !m_own));
            check("dma_ack", 64'(dma_ack), 64'(e_ack && m_own));
            check("owner", 64'(owner), 64'(m_own));
            check("cpu_rdata", 64'(cpu_rdata), 64'(e_cpu_rd));
            check("dma_rdata", 64'(dma_rdata), 64'(e_dma_rd));
            if (e_en) begin
                check("mem_addr", 64'(mem_addr), 64'(m_addr));
                check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end
        end
    end

    // One transaction from an idle start; moves the requester's address to alt once the access begins.
    task automatic xact(input bit dma, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] alt, output int en_n, output int we_n, output int ack_n,
                        output bit addr_ok);
        en_n = 0; we_n = 0; ack_n = -1; addr_ok = 1'b1;
        if (dma) begin dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1; end
        else begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
        for (int n = 1; n <= 20 && ack_n < 0; n++) begin
            @(negedge clk);
            if (mem_en) begin
                en_n++;
                if (mem_we) we_n++;
                if (mem_addr !== addr) addr_ok = 1'b0;
                if (dma) dma_addr = alt; else cpu_addr = alt;
            end
            if (dma ? dma_ack : cpu_ack) ack_n = n;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_ops(input bit dma);
        logic [31:0] a;
        a = $urandom();
        a[7:4] = 4'($urandom_range(0, 1));
        if (dma) begin dma_we = 1'($urandom_range(0, 1)); dma_addr = a; dma_wdata = $urandom(); end
        else begin cpu_we = 1'($urandom_range(0, 1)); cpu_addr = a; cpu_wdata = $urandom(); end
    endtask

    initial begin
        int  en_n, we_n, ack_n, ca, da, nack;
        bit  addr_ok;
        bit  exp_who;

        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // CPU read of 0x40 with the address moved to 0x80 mid-access.
        xact(1'b0, 1'b0, 32'h40, 32'h0, 32'h80, en_n, we_n, ack_n, addr_ok);
        check("t1_en_cycles", 64'(en_n), 64'd2);
        check("t1_ack_lat", 64'(ack_n), 64'd3);
        check("t1_addr_held", 64'(addr_ok), 64'd1);
        check("t1_cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
        check("t1_dma_rdata", 64'(dma_rdata), 64'd0);

        // DMA write then CPU read-back of the same word.
        xact(1'b1, 1'b1, 32'h10, 32'h12345678, 32'h10, en_n, we_n, ack_n, addr_ok);
        check("t2_we_cycles", 64'(we_n), 64'd2);
        check("t2_ack_lat", 64'(ack_n), 64'd3);
        check("t2_dma_rdata", 64'(dma_rdata), 64'd0);
        xact(1'b0, 1'b0, 32'h10, 32'h0, 32'h10, en_n, we_n, ack_n, addr_ok);
        check("t2_readback", 64'(cpu_rdata), 64'h12345678);

        // DMA request arriving while the CPU access is in flight.
        cpu_we = 1'b0; cpu_addr = 32'h80; dma_we = 1'b0; dma_addr = 32'h40; cpu_req = 1'b1;
        ca = -1; da = -1;
        for (int n = 1; n <= 30 && da < 0; n++) begin
            @(negedge clk);
            if (n == 1) dma_req = 1'b1;
            if (cpu_ack) begin ca = n; cpu_req = 1'b0; end
            if (dma_ack) begin da = n; dma_req = 1'b0; end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("t3_cpu_ack", 64'(ca), 64'd3);
        check("t3_dma_gap", 64'(da - ca), 64'd4);
        check("t3_cpu_rdata", 64'(cpu_rdata), 64'hCAFEF00D);
        check("t3_dma_rdata", 64'(dma_rdata), 64'hDEADBEEF);
        @(negedge clk);

        // Both requesters held high: four grants, one every LAT+2 cycles.
        cpu_we = 1'b0; cpu_addr = 32'h40; dma_we = 1'b0; dma_addr = 32'h80;
        cpu_req = 1'b1; dma_req = 1'b1; nack = 0;
        for (int n = 1; n <= 40 && nack < 4; n++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) begin
`ifdef MEM_ARB_RR_EN
                exp_who = nack[0];
`else
                exp_who = 1'b0;
`endif
                check($sformatf("t4_who_%0d", nack), 64'(dma_ack), 64'(exp_who));
                check($sformatf("t4_time_%0d", nack), 64'(n), 64'(3 + 4 * nack));
                nack++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("t4_acks", 64'(nack), 64'd4);
        @(negedge clk);

        // Reset during the first access cycle drops the transaction.
        cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
        @(negedge clk);
        check("t5_in_access", 64'(mem_en), 64'd1);
        reset = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("t5_mem_en", 64'(mem_en), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        ca = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack) ca++;
        end
        check("t5_no_ack", 64'(ca), 64'd0);
        check("t5_cpu_rdata", 64'(cpu_rdata), 64'd0);

        // Randomized traffic with occasional resets, checked cycle by cycle against the model.
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 249) == 0) reset = 1'b0;
            if (cpu_req && cpu_ack) begin
                if ($urandom_range(0, 2) == 0) rand_ops(1'b0); else cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 1) == 0) begin
                rand_ops(1'b0); cpu_req = 1'b1;
            end
            if (dma_req && dma_ack) begin
                if ($urandom_range(0, 2) == 0) rand_ops(1'b1); else dma_req = 1'b0;
            end else if (!dma_req && $urandom_range(0, 1) == 0) begin
                rand_ops(1'b1); dma_req = 1'b1;
            end
        end
        reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
